// File: rtl/sop_sweep_if.sv
// sop_sweep_if: host/datapath signals of the SOP sweep controller (master = controller, slave = host/datapath side)
interface sop_sweep_if;
  logic        start;
  logic [15:0] expected;
  logic        z1;
  logic        x1, x2, x3, x4;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic [4:0]  err_count;
  logic        mismatch;
  modport master (
    input  start, expected, z1,
    output x1, x2, x3, x4, busy, done, tt, err_count, mismatch
  );
  modport slave (
    output start, expected, z1,
    input  x1, x2, x3, x4, busy, done, tt, err_count, mismatch
  );
endinterface

// File: rtl/sop_sweep_ctrl.sv
// sop_sweep_ctrl: drives all 16 vectors into a 4-input SOP datapath, captures z1 into tt and counts mismatches vs expected (ports: clk, rst, bus master)
module sop_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  sop_sweep_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] last_cnt = 4'(SETTLE - 1);
  state_t      state, state_n;
  logic [3:0]  idx, cnt;
  logic [15:0] exp_q;
  logic        z_hi, miss, accept;
  logic [4:0]  err_n;
  assign {bus.x1, bus.x2, bus.x3, bus.x4} = idx;
  always_comb begin
    z_hi   = bus.z1 === 1'b1;
    miss   = bus.z1 !== exp_q[idx];
    err_n  = bus.err_count + 5'(miss && bus.err_count != 5'd16);
    accept = state == IDLE && bus.start;
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? DRIVE : IDLE;
      DRIVE:   state_n = cnt == last_cnt ? SAMPLE : DRIVE;
      SAMPLE:  state_n = idx == 4'd15 ? DONE : DRIVE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.tt        <= '0;
      bus.err_count <= '0;
      bus.mismatch  <= 1'b0;
    end else begin
      bus.busy <= state_n == DRIVE || state_n == SAMPLE;
      bus.done <= state_n == DONE;
      if (accept) begin
        idx           <= '0;
        cnt           <= '0;
        exp_q         <= bus.expected;
        bus.tt        <= '0;
        bus.err_count <= '0;
        bus.mismatch  <= 1'b0;
      end
      if (state == DRIVE) cnt <= cnt + 4'd1;
      if (state == SAMPLE) begin
        bus.tt[idx]   <= z_hi;
        bus.err_count <= err_n;
        bus.mismatch  <= err_n != 5'd0;
        if (idx != 4'd15) begin
          idx <= idx + 4'd1;
          cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb_sop_sweep_ctrl: directed table-driven bench for sop_sweep_ctrl with SETTLE=2
module tb_sop_sweep_ctrl;
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] expv;
    logic [15:0] tt;
    logic [4:0]  err;
    logic        mis;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] xs;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[6];
  sop_sweep_if bus();
  sop_sweep_ctrl #(.SETTLE(2)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  assign xs = {bus.x1, bus.x2, bus.x3, bus.x4};
  assign bus.z1 = mode == 2'd0 ? ((bus.x1 & bus.x2) | (bus.x3 & bus.x4) | (~bus.x2 & ~bus.x3))
                : mode == 2'd1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " x"}, 32'(xs), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " tt"}, 32'(bus.tt), 0);
    chk({tag, " err"}, 32'(bus.err_count), 0);
    chk({tag, " mis"}, 32'(bus.mismatch), 0);
  endtask
  task automatic run_sweep(input int again_at, output int first_done, output int dones,
                           output bit busy_at_done, output bit x_ok);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    first_done = 0;
    dones = 0;
    busy_at_done = 1'b1;
    x_ok = xs == 4'd0 && bus.busy;
    for (int n = 1; n <= 55; n++) begin
      bus.start = n == again_at;
      if (n == 10) bus.expected = ~bus.expected;
      @(posedge clk);
      #1;
      if (n < 48 && n % 3 == 0 && xs != 4'(n / 3)) x_ok = 1'b0;
      if (bus.done) begin
        dones++;
        if (first_done == 0) begin
          first_done = n + 1;
          busy_at_done = bus.busy;
        end
      end
    end
    bus.start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int fd, nd, seen, k;
    bit bd, xo;
    vecs[0] = '{2'd0, 16'hFB8B, 16'hFB8B, 5'd0, 1'b0};
    vecs[1] = '{2'd0, 16'h0000, 16'hFB8B, 5'd11, 1'b1};
    vecs[2] = '{2'd1, 16'hFFFF, 16'hFFFF, 5'd0, 1'b0};
    vecs[3] = '{2'd2, 16'hFFFF, 16'h0000, 5'd16, 1'b1};
    vecs[4] = '{2'd0, 16'hFFFF, 16'hFB8B, 5'd5, 1'b1};
    vecs[5] = '{2'd1, 16'h0000, 16'hFFFF, 5'd16, 1'b1};
    bus.start = 1'b0;
    bus.expected = 16'h0000;
    #12;
    chk_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      bus.expected = vecs[i].expv;
      run_sweep(0, fd, nd, bd, xo);
      chk($sformatf("v%0d done_cycle", i), 32'(fd), 49);
      chk($sformatf("v%0d done_pulses", i), 32'(nd), 1);
      chk($sformatf("v%0d busy_at_done", i), 32'(bd), 0);
      chk($sformatf("v%0d x_seq", i), 32'(xo), 1);
      chk($sformatf("v%0d tt", i), 32'(bus.tt), 32'(vecs[i].tt));
      chk($sformatf("v%0d err", i), 32'(bus.err_count), 32'(vecs[i].err));
      chk($sformatf("v%0d mis", i), 32'(bus.mismatch), 32'(vecs[i].mis));
    end
    mode = 2'd0;
    bus.expected = 16'hFB8B;
    run_sweep(20, fd, nd, bd, xo);
    chk("restart_ignored done_cycle", 32'(fd), 49);
    chk("restart_ignored done_pulses", 32'(nd), 1);
    chk("restart_ignored tt", 32'(bus.tt), 32'hFB8B);
    bus.expected = 16'h0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    fd = 0;
    nd = 0;
    for (int n = 1; n <= 99; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        if (fd == 0) fd = n + 1;
        else k = n + 1;
      end
      if (n == 48) chk("held tt_at_done", 32'(bus.tt), 32'hFB8B);
      if (n == 49) chk("held idle_busy", 32'(bus.busy), 0);
      if (n == 50) begin
        chk("held rearm_busy", 32'(bus.busy), 1);
        chk("held rearm_tt", 32'(bus.tt), 0);
        chk("held rearm_err", 32'(bus.err_count), 0);
      end
    end
    bus.start = 1'b0;
    chk("held first_done", 32'(fd), 49);
    chk("held second_done", 32'(k), 99);
    chk("held dones", 32'(nd), 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      @(posedge clk);
      #1;
      if (xs == 4'd5) seen = 1;
    end
    chk("rst_mid seen_idx5", 32'(seen), 1);
    chk("rst_mid pre_tt", 32'(bus.tt), 32'h000B);
    chk("rst_mid pre_err", 32'(bus.err_count), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.expected = 16'hFB8B;
    run_sweep(0, fd, nd, bd, xo);
    chk("after_rst done_cycle", 32'(fd), 49);
    chk("after_rst x_seq", 32'(xo), 1);
    chk("after_rst tt", 32'(bus.tt), 32'hFB8B);
    chk("after_rst err", 32'(bus.err_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sop_sweep_ctrl.md
SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, cycles each input vector is held before z1 is sampled; legal range 1..15.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  sweep request, sampled only in IDLE.
REQ-006 expected  input  16  golden truth table; bit i = expected z1 for vector i; latched when start is accepted.
REQ-007 z1  input  1  output of the 4-input SOP datapath under control.
REQ-008 x1, x2, x3, x4  output  1 each  datapath inputs; {x1,x2,x3,x4} = idx[3:0], with x1 as MSB.
REQ-009 busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 tt  output  16  captured truth table; bit i = sampled z1 for vector i.
REQ-012 err_count  output  5  number of vectors where sampled z1 differs from the expected bit; range 0..16.
REQ-013 mismatch  output  1  high when err_count != 0; updated and held together with err_count.

Function
REQ-014 States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered.
REQ-015 IDLE with start=1 -> DRIVE. This transition also does the following:
- sets idx=0 and the settle counter to 0;
- clears tt and err_count;
- latches expected.
REQ-016 IDLE with start=0 -> stay in IDLE. x1..x4 hold their last value (0 after reset).
REQ-017 DRIVE drives x1..x4 from idx for SETTLE cycles, then moves to SAMPLE.
REQ-018 SAMPLE lasts one cycle:
- tt[idx] <= z1;
- if z1 != expected_latched[idx], err_count increments by 1;
- a z1 value other than 0/1 stores tt[idx]=0 and counts as a mismatch.
REQ-019 SAMPLE with idx<15 -> idx <= idx+1, settle counter cleared, back to DRIVE.
REQ-020 SAMPLE with idx=15 -> DONE. idx does not wrap during the sweep.
REQ-021 DONE: done=1 for exactly one cycle, busy=0, then -> IDLE unconditionally.
REQ-022 busy=1 exactly in DRIVE and SAMPLE.
REQ-023 Sweep latency: start accepted at edge 0 gives done high during cycle 1+16*(SETTLE+1). For SETTLE=2 this is cycle 49.
REQ-024 start during DRIVE, SAMPLE or DONE is ignored. No queuing.
REQ-025 start held high continuously: IDLE is occupied for one cycle after DONE, then the next sweep begins and tt/err_count are cleared.
REQ-026 tt, err_count and mismatch hold their final values after done until the next accepted start.
REQ-027 A change on expected during a sweep has no effect on that sweep.
REQ-028 err_count saturates structurally at 16 (5 bits); it never wraps.

Reset
REQ-029 rst=1 immediately forces, regardless of clk, in any state including mid-sweep:
- state=IDLE;
- idx=0 and settle counter=0;
- x1..x4=0;
- busy=0, done=0;
- tt=16'h0000, err_count=0, mismatch=0.
REQ-030 After rst deasserts, the first rising clk edge with start=1 begins a full 16-vector sweep from idx=0.

Verification
REQ-031 Bench: SETTLE=2, z1 driven by the SOP function z1=x1x2+x3x4+~x2~x3, expected=16'hFB8B, pulse start -> done in cycle 49, tt=16'hFB8B, err_count=0, mismatch=0.
REQ-032 Bench: same datapath, expected=16'h0000 -> tt=16'hFB8B, err_count=11, mismatch=1.
REQ-033 Bench: z1 tied 1, expected=16'hFFFF -> tt=16'hFFFF, err_count=0. Then z1 tied 0 with the same expected -> err_count=16, mismatch=1.
REQ-034 Bench: pulse start again at cycle 20 of a sweep -> ignored; exactly one done pulse, still in cycle 49.
REQ-035 Bench: assert rst asynchronously while idx=5 -> all outputs at reset values before the next clk edge. Release rst and pulse start -> sweep restarts at idx=0 and done arrives in cycle 49 of the new sweep.
